// File: rtl/acc_mac_responder_if.sv
// Request/response channel between the accelerator interconnect and a
// responder endpoint. The master side issues requests and accepts responses.
interface acc_mac_responder_if #(
   parameter int DataWidth    = 32,
   parameter int AccAddrWidth = 3,
   parameter int IdWidth      = 8
);
   logic                    q_valid_i;
   logic                    q_ready_o;
   logic [AccAddrWidth-1:0] q_addr_i;
   logic [IdWidth-1:0]      q_id_i;
   logic [1:0]              q_op_i;
   logic [DataWidth-1:0]    q_arga_i;
   logic [DataWidth-1:0]    q_argb_i;
   logic                    p_valid_o;
   logic                    p_ready_i;
   logic [DataWidth-1:0]    p_data_o;
   logic [IdWidth-1:0]      p_id_o;
   logic                    p_error_o;

   modport master (
      output q_valid_i, q_addr_i, q_id_i, q_op_i, q_arga_i, q_argb_i, p_ready_i,
      input  q_ready_o, p_valid_o, p_data_o, p_id_o, p_error_o
   );

   modport slave (
      input  q_valid_i, q_addr_i, q_id_i, q_op_i, q_arga_i, q_argb_i, p_ready_i,
      output q_ready_o, p_valid_o, p_data_o, p_id_o, p_error_o
   );
endinterface

// File: rtl/acc_mac_responder.sv
// Accelerator responder: one request in flight, executes ADD/SUB in one cycle
// and MUL as a fixed DataWidth-cycle shift-add; echoes the request ID.
module acc_mac_responder #(
   parameter int DataWidth    = 32,
   parameter int AccAddrWidth = 3,
   parameter int IdWidth      = 8,
   parameter int AccAddr      = 0
) (
   input logic                clk_i,
   input logic                rst_ni,
   acc_mac_responder_if.slave bus
);
   localparam int CntWidth = $clog2(DataWidth);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
   typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_RSVD = 2'b11} op_e;

   state_e               state_q, state_d;
   logic [DataWidth-1:0] mcand_q, mcand_d;
   logic [DataWidth-1:0] mplier_q, mplier_d;
   logic [DataWidth-1:0] acc_q, acc_d;
   logic [CntWidth-1:0]  cnt_q, cnt_d;
   logic [DataWidth-1:0] p_data_q, p_data_d;
   logic [IdWidth-1:0]   p_id_q, p_id_d;
   logic                 p_error_q, p_error_d;

   logic                 q_ready;
   logic                 accept;
   logic                 addr_ok;
   op_e                  op;
   logic [DataWidth-1:0] acc_sum;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      p_data_d  = p_data_q;
      p_id_d    = p_id_q;
      p_error_d = p_error_q;
      q_ready   = 1'b0;
      op        = op_e'(bus.q_op_i);
      addr_ok   = (bus.q_addr_i == AccAddrWidth'(AccAddr));
      acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);

      case (state_q)
         IDLE: q_ready = 1'b1;
         BUSY: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CntWidth'(1);
            // Fixed iteration count: no early exit when the multiplier runs out of ones.
            if (cnt_q == CntWidth'(DataWidth - 1)) begin
               p_data_d  = acc_sum;
               p_error_d = 1'b0;
               state_d   = RESP;
            end
         end
         RESP: begin
            q_ready = bus.p_ready_i;
            if (bus.p_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      accept = bus.q_valid_i && q_ready;

      if (accept) begin
         p_id_d    = bus.q_id_i;
         p_error_d = 1'b0;
         state_d   = RESP;
         if (!addr_ok || op == OP_RSVD) begin
            p_data_d  = '0;
            p_error_d = 1'b1;
         end else begin
            case (op)
               OP_ADD: p_data_d = bus.q_arga_i + bus.q_argb_i;
               OP_SUB: p_data_d = bus.q_arga_i - bus.q_argb_i;
               default: begin
                  mcand_d  = bus.q_arga_i;
                  mplier_d = bus.q_argb_i;
                  acc_d    = '0;
                  cnt_d    = '0;
                  state_d  = BUSY;
               end
            endcase
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         // NOTE: datapath registers are reset too, so a dropped operation leaves no residue on p_*.
         state_q   <= IDLE;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         p_data_q  <= '0;
         p_id_q    <= '0;
         p_error_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         p_data_q  <= p_data_d;
         p_id_q    <= p_id_d;
         p_error_q <= p_error_d;
      end
   end

   assign bus.q_ready_o = q_ready;
   assign bus.p_valid_o = (state_q == RESP);
   assign bus.p_data_o  = p_data_q;
   assign bus.p_id_o    = p_id_q;
   assign bus.p_error_o = p_error_q;
endmodule
